maxnet_controller: RTL

//   FSM that sequences the 4-PU MaxNet datapath (dp): initialises X/W memories,

---
 rtl/maxnet_controller.sv | 115 +++++++++++
 1 files changed

// File: rtl/maxnet_controller.sv
// Sequencer for the 4-PU MaxNet datapath: init, initial load, then update/check loop until one winner.
// Optional MAXNET_WATCHDOG_EN ends a run with timeout=1 once MAX_ITER iterations complete without a winner.
module maxnet_controller #(
  parameter int PU_LATENCY = 2,
  parameter int ITER_W     = 8,
  parameter int MAX_ITER   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_finished,
  output logic              init_x,
  output logic              init_w,
  output logic              load_a,
  output logic              load_sel,
  output logic              ready,
  output logic              done,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count,
  output logic [2:0]        o_dbg_state
);

  // Handshake: a run is accepted on a rising edge where ready=1 and start=1; start is
  // ignored while ready=0; done pulses for exactly one cycle and ready returns the next cycle.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    LOAD   = 3'd2,
    CHECK  = 3'd3,
    WAIT   = 3'd4,
    UPDATE = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'((PU_LATENCY > 0) ? (PU_LATENCY - 1) : 0);
  localparam logic [ITER_W-1:0] ITER_SAT = {ITER_W{1'b1}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [ITER_W-1:0] r_iter_count;

`ifdef MAXNET_WATCHDOG_EN
  logic r_timeout;
  logic w_at_limit;
  assign w_at_limit = (r_iter_count == ITER_W'(MAX_ITER));
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (start) w_state_nxt = INIT;
      INIT:   w_state_nxt = LOAD;
      LOAD:   w_state_nxt = CHECK;
      CHECK: begin
        if (is_finished) w_state_nxt = DONE;
`ifdef MAXNET_WATCHDOG_EN
        else if (w_at_limit) w_state_nxt = DONE;
`endif
        else if (PU_LATENCY > 0) w_state_nxt = WAIT;
        else w_state_nxt = UPDATE;
      end
      WAIT:   if (r_cnt == 4'd0) w_state_nxt = UPDATE;
      UPDATE: w_state_nxt = CHECK;
      DONE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_iter_count <= '0;
`ifdef MAXNET_WATCHDOG_EN
      r_timeout    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (start) begin
          r_iter_count <= '0;
`ifdef MAXNET_WATCHDOG_EN
          r_timeout    <= 1'b0;
`endif
        end
        CHECK: begin
          r_cnt <= LAT_M1;
`ifdef MAXNET_WATCHDOG_EN
          if (!is_finished && w_at_limit) r_timeout <= 1'b1;
`endif
        end
        WAIT:   if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        UPDATE: if (r_iter_count != ITER_SAT) r_iter_count <= r_iter_count + 1'b1;
        default: ;
      endcase
    end
  end

  // All control outputs are Moore; load_sel is only ever high together with load_a.
  assign init_x      = (r_state == INIT);
  assign init_w      = (r_state == INIT);
  assign load_a      = (r_state == LOAD) || (r_state == UPDATE);
  assign load_sel    = (r_state == LOAD);
  assign ready       = (r_state == IDLE);
  assign done        = (r_state == DONE);
  assign iter_count  = r_iter_count;
  assign o_dbg_state = r_state;
`ifdef MAXNET_WATCHDOG_EN
  assign timeout     = r_timeout;
`else
  assign timeout     = 1'b0;
`endif

endmodule
